// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core sequenced FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Optional feature macro MIPS_MC_BNE_EN: when defined, bne (opcode 0x05) is decoded with
// beq timing and target; when undefined, opcode 0x05 retires as an illegal instruction.
// Memory handshake: a transfer completes on a cycle with mem_req=1 and mem_ready=1.
// mem_ready is ignored while mem_req=0. While a request waits, mem_addr, mem_we and
// mem_wdata hold their values.
module mips_multicycle #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     alu_result,
    output logic            retire,
    output logic            illegal_op,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic [31:0]       regs_q [32];

    logic              req_c, ir_ld, ab_ld, alu_ld, mdr_ld, rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       alu_d, wb_data;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic              is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_legal;
    logic              br_taken, slt_lt;
    logic [PC_W-1:0]   pc_plus4;
    logic [31:0]       pc4_ext, br_tgt, j_tgt;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];

    assign is_rtype = (opcode == 6'h00) && ((funct == 6'h20) || (funct == 6'h22) ||
                      (funct == 6'h24) || (funct == 6'h25) || (funct == 6'h2A));
    assign is_addi  = (opcode == 6'h08);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_j     = (opcode == 6'h02);
`ifdef MIPS_MC_BNE_EN
    assign is_bne   = (opcode == 6'h05);
`else
    assign is_bne   = 1'b0;
`endif
    assign is_legal = is_rtype | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;
    assign br_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    assign slt_lt   = $signed(a_q) < $signed(b_q);

    // Branch/jump targets are built at 32 bits, then truncated to the PC width.
    assign pc_plus4 = pc_q + PC_W'(4);
    assign pc4_ext  = 32'(pc_plus4);
    assign br_tgt   = pc4_ext + {imm_q[29:0], 2'b00};
    assign j_tgt    = {pc4_ext[31:28], ir_q[25:0], 2'b00};
    assign wb_data  = is_lw ? mdr_q : alu_q;

    assign mem_req    = req_c & rst_n;
    assign mem_wdata  = b_q;
    assign pc_out     = pc_q;
    assign alu_result = alu_q;
    assign dbg_state  = state_q;

    // ALU: address add by default, R-type ops by funct, compare-subtract for branches.
    always_comb begin
        alu_d = a_q + imm_q;
        if (is_rtype) begin
            case (funct)
                6'h22:   alu_d = a_q - b_q;
                6'h24:   alu_d = a_q & b_q;
                6'h25:   alu_d = a_q | b_q;
                6'h2A:   alu_d = {31'd0, slt_lt};
                default: alu_d = a_q + b_q;
            endcase
        end else if (is_beq || is_bne) begin
            alu_d = a_q - b_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state, memory request outputs, retire pulses and datapath load enables.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_q;
        retire     = 1'b0;
        illegal_op = 1'b0;
        pc_d       = pc_q;
        ir_ld      = 1'b0;
        ab_ld      = 1'b0;
        alu_ld     = 1'b0;
        mdr_ld     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_ld   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_ld = 1'b1;
                if (is_rtype || is_addi) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    retire     = 1'b1;
                    illegal_op = ~is_legal;
                    state_d    = S_FETCH;
                    if (br_taken)  pc_d = br_tgt[PC_W-1:0];
                    else if (is_j) pc_d = j_tgt[PC_W-1:0];
                    else           pc_d = pc_plus4;
                end
            end
            S_MEM: begin
                req_c    = 1'b1;
                mem_we   = is_sw;
                mem_addr = alu_q[PC_W-1:0];
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end else begin
                        mdr_ld  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = is_rtype ? rd : rt;
                retire   = 1'b1;
                pc_d     = pc_plus4;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath registers: PC, instruction, operands, ALU output and load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC[PC_W-1:0];
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (ir_ld) ir_q <= mem_rdata;
            if (ab_ld) begin
                a_q   <= regs_q[rs];
                b_q   <= regs_q[rt];
                imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
            end
            if (alu_ld) alu_q <= alu_d;
            if (mdr_ld) mdr_q <= mem_rdata;
        end
    end

    // Register file; register 0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs_q[rf_waddr] <= wb_data;
        end
    end

endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 SHALL have parameter PC_W, default 32, legal range 8..32: program-counter and memory-address width.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded at reset (word aligned).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  memory transfer request.
REQ-006 SHALL have port mem_we  output  1  1 = store, 0 = fetch or load.
REQ-007 SHALL have port mem_addr  output  PC_W  byte address of the transfer.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  fetch or load data, valid while mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  transfer completes on a cycle with mem_req=1 and mem_ready=1.
REQ-011 SHALL have port pc_out  output  PC_W  current PC.
REQ-012 SHALL have port alu_result  output  32  last registered ALU output.
REQ-013 SHALL have port retire  output  1  one-cycle pulse when an instruction completes.
REQ-014 SHALL have port illegal_op  output  1  one-cycle pulse, coincident with retire, for an undecoded opcode or funct.

Function
REQ-015 SHALL implement a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB.
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC; it SHALL hold until mem_ready=1, then latch IR and go to DECODE.
REQ-017 DECODE SHALL read rs and rt from a 32x32 register file, sign-extend imm16, and go to EXEC.
REQ-018 EXEC SHALL execute R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
REQ-019 Routing from EXEC: R-type and addi SHALL go to WB; lw and sw SHALL go to MEM; beq, j and illegal opcodes SHALL retire and go to FETCH.
REQ-020 MEM SHALL drive mem_req=1 with mem_addr=(rs+sext(imm))[PC_W-1:0] and mem_we=1 for sw; it SHALL hold every output stable until mem_ready=1.
REQ-021 After MEM, sw SHALL retire and go to FETCH; lw SHALL latch mem_rdata and go to WB.
REQ-022 WB SHALL write rd (R-type), rt (addi), or the loaded word (lw), then retire and go to FETCH.
REQ-023 Minimum latency at mem_ready=1: 3 cycles for beq/j/illegal, 4 for R-type/addi/sw, 5 for lw; each wait cycle SHALL add one cycle.
REQ-024 Every retired instruction SHALL set PC to PC+4, except a taken beq and j.
REQ-025 Taken beq (rs==rt) SHALL set PC to PC+4+(sext(imm)<<2); j SHALL set PC to {(PC+4)[PC_W-1:28], instr[25:0], 2'b00}, both truncated to PC_W bits.
REQ-026 All adds SHALL wrap modulo 2^32 (data) and 2^PC_W (PC) with no overflow trap; slt SHALL compare signed.
REQ-027 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-028 mem_req SHALL be 0 in DECODE, EXEC and WB.
REQ-029 mem_ready while mem_req=0 SHALL be ignored.
REQ-030 An illegal instruction SHALL write no register and no memory.
REQ-031 mem_addr bits [1:0] SHALL be passed through unmodified; no alignment check is made.

Reset
REQ-032 rst_n=0 SHALL immediately force state=FETCH, PC=RESET_PC, IR=0, all registers=0, alu_result=0, mem_req=0, mem_we=0, mem_wdata=0, retire=0, illegal_op=0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no register write; the first cycle after release SHALL assert mem_req in FETCH.

Configuration
REQ-034 Macro MIPS_MC_BNE_EN defined: bne (opcode 0x05) SHALL be decoded and branch when rs!=rt, with beq timing and target.
REQ-035 Macro MIPS_MC_BNE_EN undefined: opcode 0x05 SHALL be illegal (illegal_op pulse, PC+4).

Verification
REQ-036 Reset release with RESET_PC=0x100 and mem_ready=1 -> first mem_addr=0x100 in the cycle after release.
REQ-037 Run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, alu_result=1, retire pulses 4 cycles apart.
REQ-038 sw $1,8($0) then lw $5,8($0) with mem_ready delayed 3 cycles -> store of data 5 to address 8; $5=5; lw takes 11 cycles; mem_addr/mem_we/mem_wdata stable while waiting.
REQ-039 beq $0,$0,-1 at PC=0x40 -> PC returns to 0x40; j 0x3FFFFFF with PC_W=16 -> PC=0xFFFC.
REQ-040 Opcode 0x05 -> illegal_op pulse and PC+4 without MIPS_MC_BNE_EN; branch taken when rs!=rt with it defined.
REQ-041 rst_n pulled low during the MEM wait of a lw -> mem_req=0 immediately, destination register unchanged, fetch restarts at RESET_PC.
